// File: rtl/cordic_engine_pkg.sv
// cordic_engine_pkg: FSM states, arctangent table and 1/K gain shared by the CORDIC engine
package cordic_engine_pkg;

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

    // atan(2^-i) for a full circle of 2^32; narrower angle formats are rounded from it
    localparam logic [31:0] ATAN32 [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    localparam logic [31:0] INV_GAIN_Q32 = 32'd2608131496;

    function automatic logic [31:0] atan_lut(input logic [4:0] i, input int pw);
        logic [32:0] v;
        v = {1'b0, ATAN32[i]} + (33'd1 << (31 - pw));
        return 32'(v >> (32 - pw));
    endfunction

    function automatic int inv_gain(input int dw);
        logic [32:0] v;
        v = {1'b0, INV_GAIN_Q32} + (33'd1 << (30 - dw));
        return int'(32'(v >> (31 - dw)));
    endfunction

endpackage

// File: rtl/cordic_engine_if.sv
// cordic_engine_if: input and output valid/ready streams of the CORDIC engine
interface cordic_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PHI_WIDTH  = 16,
    parameter int TAG_WIDTH  = 4
);
    logic                         in_valid, in_ready, in_mode, out_valid, out_ready;
    logic signed [DATA_WIDTH-1:0] in_x, in_y, out_x, out_y;
    logic [PHI_WIDTH-1:0]         in_phi, out_phi;
    logic [TAG_WIDTH-1:0]         in_tag, out_tag;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_phi, in_tag, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_phi, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_phi, in_tag, out_ready,
        output in_ready, out_valid, out_x, out_y, out_phi, out_tag
    );
endinterface

// File: rtl/cordic_engine_gain_sat.sv
// cordic_engine_gain_sat: multiply by 1/K, round half-up and saturate to a symmetric range
module cordic_engine_gain_sat #(
    parameter int DW   = 16,
    parameter int GAIN = 79594
) (
    input  logic signed [DW+1:0] v_i,
    output logic signed [DW-1:0] v_o
);
    localparam int PW = 2 * DW + 4;
    localparam logic signed [PW-1:0] G    = PW'(GAIN);
    localparam logic signed [PW-1:0] HALF = PW'(1) << DW;
    localparam logic signed [PW-1:0] MAX  = (PW'(1) << (DW - 1)) - PW'(1);
    localparam logic signed [DW-1:0] SMAX = MAX[DW-1:0];

    logic signed [PW-1:0] p, r;

    always_comb begin
        p   = PW'(v_i) * G;
        r   = (p + HALF) >>> (DW + 1);
        v_o = r > MAX ? SMAX : r < -MAX ? -SMAX : r[DW-1:0];
    end
endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: serial multi-mode CORDIC (rotate / vector) behind valid/ready streams
module cordic_engine
    import cordic_engine_pkg::*;
#(
    parameter int N          = 14,
    parameter int DATA_WIDTH = 16,
    parameter int PHI_WIDTH  = 16,
    parameter int TAG_WIDTH  = 4
) (
    input logic            clk,
    input logic            rst_n,
    cordic_engine_if.slave bus
);
    localparam int XW       = DATA_WIDTH + 2;
    localparam int ZW       = PHI_WIDTH + 1;
    localparam int IW       = $clog2(N);
    localparam int INV_GAIN = inv_gain(DATA_WIDTH);
    localparam logic signed [ZW-1:0] PI = {2'b01, {(PHI_WIDTH - 1){1'b0}}};

    state_t                       state_q;
    logic                         in_ready_q, out_valid_q, mode_q, fold, dpos;
    logic signed [XW-1:0]         x_q, y_q, x_d, y_d, xs, ys;
    logic signed [ZW-1:0]         z_q, z_d, z_pre, at;
    logic [IW-1:0]                i_q;
    logic [TAG_WIDTH-1:0]         tag_q, out_tag_q;
    logic signed [DATA_WIDTH-1:0] out_x_q, out_y_q, gx, gy;
    logic [PHI_WIDTH-1:0]         out_phi_q, phi_f;

    // Fold into the right half-plane so the micro-rotations can converge
    always_comb begin
        fold  = mode_q ? x_q[XW-1] : z_q[PHI_WIDTH-1] ^ z_q[PHI_WIDTH-2];
        phi_f = {z_q[PHI_WIDTH-1] ^ fold, z_q[PHI_WIDTH-2:0]};
        z_pre = mode_q ? (fold ? PI : '0) : {phi_f[PHI_WIDTH-1], phi_f};
        dpos  = mode_q ? y_q[XW-1] : ~z_q[ZW-1];
        xs    = x_q >>> i_q;
        ys    = y_q >>> i_q;
        at    = ZW'(atan_lut(5'(i_q), PHI_WIDTH));
        x_d   = dpos ? x_q - ys : x_q + ys;
        y_d   = dpos ? y_q + xs : y_q - xs;
        z_d   = dpos ? z_q - at : z_q + at;
    end

    cordic_engine_gain_sat #(.DW(DATA_WIDTH), .GAIN(INV_GAIN)) u_gx (.v_i(x_q), .v_o(gx));
    cordic_engine_gain_sat #(.DW(DATA_WIDTH), .GAIN(INV_GAIN)) u_gy (.v_i(y_q), .v_o(gy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            tag_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_phi_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        mode_q     <= bus.in_mode;
                        x_q        <= XW'(bus.in_x);
                        y_q        <= XW'(bus.in_y);
                        z_q        <= ZW'(bus.in_phi);
                        tag_q      <= bus.in_tag;
                        state_q    <= PRE;
                    end
                end
                PRE: begin
                    x_q     <= fold ? -x_q : x_q;
                    y_q     <= fold ? -y_q : y_q;
                    z_q     <= z_pre;
                    i_q     <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    z_q     <= z_d;
                    i_q     <= i_q + 1'b1;
                    state_q <= i_q == IW'(N - 1) ? POST : ITER;
                end
                POST: begin
                    out_x_q     <= gx;
                    out_y_q     <= mode_q ? y_q[DATA_WIDTH-1:0] : gy;
                    out_phi_q   <= z_q[PHI_WIDTH-1:0];
                    out_tag_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_phi   = out_phi_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed vectors with hand-computed results for the CORDIC engine
module tb_cordic_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, passed = 0;
    int   lat, ox, oy, ophi, otag;
    logic stable, seen;

    always #5 clk = ~clk;

    cordic_engine_if #(.DATA_WIDTH(16), .PHI_WIDTH(16), .TAG_WIDTH(4)) bif ();

    cordic_engine #(.N(14), .DATA_WIDTH(16), .PHI_WIDTH(16), .TAG_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) passed++;
        else $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    endtask

    task automatic grab();
        ox   = int'(bif.out_x);
        oy   = int'(bif.out_y);
        ophi = int'(bif.out_phi);
        otag = int'(bif.out_tag);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge
    task automatic send(input logic m, input int x, input int y, input int phi, input int tag);
        int w = 0;
        while (!bif.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", int'(w < 50), 1, 0);
        bif.in_valid = 1'b1;
        bif.in_mode  = m;
        bif.in_x     = 16'(x);
        bif.in_y     = 16'(y);
        bif.in_phi   = 16'(phi);
        bif.in_tag   = 4'(tag);
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic run(input logic m, input int x, input int y, input int phi, input int tag);
        send(m, x, y, phi, tag);
        lat = 0;
        while (!bif.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        grab();
    endtask

    task automatic ack();
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_mode   = 1'b0;
        bif.in_x      = '0;
        bif.in_y      = '0;
        bif.in_phi    = '0;
        bif.in_tag    = '0;
        bif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bif.in_ready), 0, 0);
        chk("rst_out_valid", int'(bif.out_valid), 0, 0);
        chk("rst_out_zero", int'(|{bif.out_x, bif.out_y, bif.out_phi, bif.out_tag}), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(bif.in_ready), 1, 0);

        run(1'b0, 16384, 0, 'h4000, 1);
        chk("rot90_latency", lat, 16, 0);
        chk("rot90_x", ox, 0, 4);
        chk("rot90_y", oy, 16384, 4);
        chk("rot90_tag", otag, 1, 0);
        ack();

        run(1'b0, 16384, 0, 'hA000, 2);
        chk("rot_m135_x", ox, -11585, 4);
        chk("rot_m135_y", oy, -11585, 4);
        chk("rot_m135_tag", otag, 2, 0);
        ack();

        run(1'b1, -16384, 0, 0, 3);
        chk("vec_negx_latency", lat, 16, 0);
        chk("vec_negx_mag", ox, 16384, 4);
        chk("vec_negx_phi", ophi, 'h8000, 8);
        ack();

        run(1'b1, 0, -16384, 0, 4);
        chk("vec_negy_mag", ox, 16384, 4);
        chk("vec_negy_phi", ophi, 'hC000, 8);
        ack();

        run(1'b1, 32767, 32767, 0, 'hA);
        chk("vec_sat_mag", ox, 32767, 0);
        chk("vec_sat_phi", ophi, 'h2000, 8);
        chk("vec_sat_tag", otag, 'hA, 0);

        stable = 1'b1;
        seen   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bif.in_valid = (k == 4);
            bif.in_mode  = 1'b0;
            bif.in_x     = 16'sd100;
            bif.in_tag   = 4'h5;
            @(negedge clk);
            stable &= bif.out_valid && int'(bif.out_x) == ox && int'(bif.out_y) == oy &&
                      int'(bif.out_phi) == ophi && int'(bif.out_tag) == otag;
            seen |= bif.in_ready;
        end
        bif.in_valid = 1'b0;
        chk("bp_stable", int'(stable), 1, 0);
        chk("bp_in_ready_low", int'(seen), 0, 0);
        ack();
        chk("bp_release_ready", int'(bif.in_ready), 1, 0);
        chk("bp_release_valid", int'(bif.out_valid), 0, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= bif.out_valid;
        end
        chk("bp_pulse_dropped", int'(seen), 0, 0);

        send(1'b0, 16384, 0, 'h4000, 5);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bif.out_valid), 0, 0);
        chk("midrst_in_ready", int'(bif.in_ready), 0, 0);
        chk("midrst_out_zero", int'(|{bif.out_x, bif.out_y, bif.out_phi, bif.out_tag}), 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= bif.out_valid;
        end
        chk("midrst_no_stale", int'(seen), 0, 0);

        run(1'b1, -16384, 0, 0, 6);
        chk("post_rst_latency", lat, 16, 0);
        chk("post_rst_mag", ox, 16384, 4);
        chk("post_rst_phi", ophi, 'h8000, 8);
        chk("post_rst_tag", otag, 6, 0);
        ack();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
